// File: rtl/simple_write_arbiter.sv
// rtl/simple_write_arbiter.sv - round-robin arbiter sharing one simple-write master port
// The grant is held for a whole transfer; zero-length requests complete locally.
module simple_write_arbiter #(
  parameter int N_REQ      = 4,
  parameter int AXI_ADDR_W = 32,
  parameter int AXI_DATA_W = 32,
  parameter int LEN_W      = 8,
  localparam int STRB_W    = AXI_DATA_W / 8,
  localparam int IDX_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [N_REQ-1:0]          r_wvalid_i,
  output logic [N_REQ-1:0]          r_wready_o,
  input  logic [N_REQ*AXI_ADDR_W-1:0] r_waddr_i,
  input  logic [N_REQ*AXI_DATA_W-1:0] r_wdata_i,
  input  logic [N_REQ*STRB_W-1:0]   r_wstrb_i,
  input  logic [N_REQ*LEN_W-1:0]    r_wlen_i,
  output logic [N_REQ-1:0]          r_wlast_o,
  output logic                      m_wvalid_o,
  input  logic                      m_wready_i,
  output logic [AXI_ADDR_W-1:0]     m_waddr_o,
  output logic [AXI_DATA_W-1:0]     m_wdata_o,
  output logic [STRB_W-1:0]         m_wstrb_o,
  output logic [LEN_W-1:0]          m_wlen_o,
  input  logic                      m_wlast_i,
  output logic [IDX_W-1:0]          gnt_o,
  output logic                      busy_o,
  output logic [N_REQ-1:0]          zero_len_err_o
);

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_ZERO} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;

  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_zero;
  logic [IDX_W-1:0] gnt_inc;
  int               cand;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      gnt_q    <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // First valid requester at or after rr_ptr, scanning modulo N_REQ.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = (int'(rr_ptr_q) + i) % N_REQ;
      if (!pick_found && r_wvalid_i[IDX_W'(cand)]) begin
        pick_found = 1'b1;
        pick_idx   = IDX_W'(cand);
      end
    end
  end

  assign pick_zero = (r_wlen_i[pick_idx*LEN_W +: LEN_W] == '0);
  assign gnt_inc   = (gnt_q == IDX_W'(N_REQ - 1)) ? '0 : gnt_q + 1'b1;
  assign gnt_o     = gnt_q;

  always_comb begin
    state_d        = state_q;
    gnt_d          = gnt_q;
    rr_ptr_d       = rr_ptr_q;
    r_wready_o     = '0;
    r_wlast_o      = '0;
    zero_len_err_o = '0;
    busy_o         = 1'b0;
    m_wvalid_o     = 1'b0;
    m_waddr_o      = '0;
    m_wdata_o      = '0;
    m_wstrb_o      = '0;
    m_wlen_o       = '0;
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          gnt_d   = pick_idx;
          state_d = pick_zero ? ST_ZERO : ST_BUSY;
        end
      end
      ST_BUSY: begin
        busy_o             = 1'b1;
        m_wvalid_o         = r_wvalid_i[gnt_q];
        m_waddr_o          = r_waddr_i[gnt_q*AXI_ADDR_W +: AXI_ADDR_W];
        m_wdata_o          = r_wdata_i[gnt_q*AXI_DATA_W +: AXI_DATA_W];
        m_wstrb_o          = r_wstrb_i[gnt_q*STRB_W +: STRB_W];
        m_wlen_o           = r_wlen_i[gnt_q*LEN_W +: LEN_W];
        r_wready_o[gnt_q]  = m_wready_i;
        r_wlast_o[gnt_q]   = m_wlast_i;
        if (r_wvalid_i[gnt_q] && m_wready_i && m_wlast_i) begin
          state_d  = ST_IDLE;
          rr_ptr_d = gnt_inc;
        end
      end
      ST_ZERO: begin
        // The bridge never sees a zero-length request; acknowledge it here.
        r_wready_o[gnt_q]     = 1'b1;
        r_wlast_o[gnt_q]      = 1'b1;
        zero_len_err_o[gnt_q] = 1'b1;
        state_d               = ST_IDLE;
        rr_ptr_d              = gnt_inc;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_simple_write_arbiter.sv
// tb/tb_simple_write_arbiter.sv - self-checking bench for simple_write_arbiter
module tb_simple_write_arbiter;
  localparam int N = 4, AW = 32, DW = 32, SW = 4, LW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [N-1:0]  v;
  logic [AW-1:0] addr [N];
  logic [DW-1:0] dat  [N];
  logic [SW-1:0] stb  [N];
  logic [LW-1:0] len  [N];
  logic [N*AW-1:0] addr_p;
  logic [N*DW-1:0] dat_p;
  logic [N*SW-1:0] stb_p;
  logic [N*LW-1:0] len_p;
  logic m_wready, m_wlast;

  logic [N-1:0]  r_wready, r_wlast, zerr;
  logic          m_wvalid, busy;
  logic [AW-1:0] m_waddr;
  logic [DW-1:0] m_wdata;
  logic [SW-1:0] m_wstrb;
  logic [LW-1:0] m_wlen;
  logic [1:0]    gnt;

  always_comb begin
    for (int k = 0; k < N; k++) begin
      addr_p[k*AW +: AW] = addr[k];
      dat_p[k*DW +: DW]  = dat[k];
      stb_p[k*SW +: SW]  = stb[k];
      len_p[k*LW +: LW]  = len[k];
    end
  end

  simple_write_arbiter #(.N_REQ(N), .AXI_ADDR_W(AW), .AXI_DATA_W(DW), .LEN_W(LW)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .r_wvalid_i(v), .r_wready_o(r_wready), .r_waddr_i(addr_p), .r_wdata_i(dat_p),
    .r_wstrb_i(stb_p), .r_wlen_i(len_p), .r_wlast_o(r_wlast),
    .m_wvalid_o(m_wvalid), .m_wready_i(m_wready), .m_waddr_o(m_waddr), .m_wdata_o(m_wdata),
    .m_wstrb_o(m_wstrb), .m_wlen_o(m_wlen), .m_wlast_i(m_wlast),
    .gnt_o(gnt), .busy_o(busy), .zero_len_err_o(zerr)
  );

  // Reference: phase 0 idle, 1 forwarding, 2 local zero-length completion.
  int ms, mg, mrr, mbeat, done_k;
  int grants[$];
  int n_cmp = 0, n_fail = 0;
  int dut_beats;
  bit dut_err_seen, dut_mv_seen, rnd_mode;

  typedef struct {int req; int ln; logic [31:0] ad; int beats; bit zero;} vec_t;
  vec_t tbl[6];

  function automatic int nbeats(input int l);
    return (l + SW - 1) / SW;
  endfunction

  function automatic int order_code();
    int c = 1;
    foreach (grants[i]) c = c * 16 + grants[i];
    return c;
  endfunction

  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic timeout(input string nm);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: timeout, got busy, expected idle at %0t", nm, $time);
  endtask

  task automatic reset_check(input string nm);
    cmp({nm, "_ctl"}, 64'({r_wready, r_wlast, zerr, m_wvalid, busy, gnt}), 64'd0);
    cmp({nm, "_addr_data"}, {m_waddr, m_wdata}, 64'd0);
    cmp({nm, "_strb_len"}, 64'({m_wstrb, m_wlen}), 64'd0);
  endtask

  task automatic check_outputs();
    logic [N-1:0] er, el, ee;
    logic emv, eb;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    logic [SW-1:0] es;
    logic [LW-1:0] eln;
    er = '0; el = '0; ee = '0; emv = 1'b0; eb = 1'b0; ea = '0; ed = '0; es = '0; eln = '0;
    if (ms == 1) begin
      eb = 1'b1; emv = v[mg]; ea = addr[mg]; ed = dat[mg]; es = stb[mg]; eln = len[mg];
      er[mg] = m_wready; el[mg] = m_wlast;
    end else if (ms == 2) begin
      er[mg] = 1'b1; el[mg] = 1'b1; ee[mg] = 1'b1;
    end
    cmp("gnt", 64'(gnt), 64'(mg));
    cmp("busy", 64'(busy), 64'(eb));
    cmp("zero_len_err", 64'(zerr), 64'(ee));
    cmp("r_wready", 64'(r_wready), 64'(er));
    cmp("r_wlast", 64'(r_wlast), 64'(el));
    cmp("m_wvalid", 64'(m_wvalid), 64'(emv));
    if (ms != 2) begin
      cmp("m_waddr", 64'(m_waddr), 64'(ea));
      cmp("m_wdata", 64'(m_wdata), 64'(ed));
      cmp("m_wstrb_len", 64'({m_wstrb, m_wlen}), 64'({es, eln}));
    end
  endtask

  task automatic step_model();
    int w;
    done_k = -1;
    case (ms)
      0: begin
        w = -1;
        for (int i = 0; i < N; i++) begin
          int c;
          c = (mrr + i) % N;
          if (w < 0 && v[c]) w = c;
        end
        if (w >= 0) begin
          mg = w; grants.push_back(w); mbeat = 0;
          ms = (len[w] == 0) ? 2 : 1;
        end
      end
      1: if (v[mg] && m_wready) begin
        if (m_wlast) begin ms = 0; mrr = (mg + 1) % N; done_k = mg; end
        else mbeat++;
      end
      default: begin ms = 0; mrr = (mg + 1) % N; done_k = mg; end
    endcase
  endtask

  // One clock: bridge drives last from the reference beat count, check, advance.
  task automatic cycle();
    if (ms == 1) m_wlast = (mbeat == nbeats(int'(len[mg])) - 1);
    else if (rnd_mode) m_wlast = 1'($urandom_range(0, 1));
    else m_wlast = 1'b0;
    #1;
    check_outputs();
    if (m_wvalid && m_wready) dut_beats++;
    if (zerr != '0) dut_err_seen = 1'b1;
    if (m_wvalid) dut_mv_seen = 1'b1;
    step_model();
    @(posedge clk);
    #1;
    if (done_k >= 0) v[done_k] = 1'b0;
  endtask

  task automatic req(input int k, input int l, input logic [31:0] a);
    v[k] = 1'b1; len[k] = LW'(l); addr[k] = a; dat[k] = $urandom; stb[k] = SW'($urandom);
  endtask

  task automatic run_until_idle(input int budget, input string nm);
    int n = 0;
    while ((v != '0 || ms != 0) && n < budget) begin
      cycle();
      n++;
    end
    if (n >= budget) timeout(nm);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got running, expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    tbl[0] = '{1, 8,   32'h100, 2,  1'b0};
    tbl[1] = '{2, 0,   32'h200, 0,  1'b1};
    tbl[2] = '{0, 4,   32'h040, 1,  1'b0};
    tbl[3] = '{3, 12,  32'h300, 3,  1'b0};
    tbl[4] = '{1, 1,   32'h104, 1,  1'b0};
    tbl[5] = '{0, 255, 32'h000, 64, 1'b0};

    rst_n = 1'b0; m_wready = 1'b1; m_wlast = 1'b1; rnd_mode = 1'b0; v = '1;
    for (int k = 0; k < N; k++) req(k, 4, 32'h10 * k);
    ms = 0; mg = 0; mrr = 0; mbeat = 0;
    #12;
    reset_check("reset");
    v = '0; m_wlast = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Simultaneous requests after reset: strict order from rr_ptr=0.
    grants.delete();
    req(0, 4, 32'h1000); req(2, 4, 32'h2000); req(3, 4, 32'h3000);
    run_until_idle(50, "t2");
    cmp("t2_order", 64'(order_code()), 64'h1023);

    // Wrap-around: 2, then 3 alone, then 3 and 0 together -> 0 first.
    grants.delete();
    req(2, 4, 32'h2100);
    run_until_idle(20, "t3a");
    req(3, 4, 32'h3100);
    run_until_idle(20, "t3b");
    req(3, 8, 32'h3200); req(0, 8, 32'h0200);
    run_until_idle(40, "t3c");
    cmp("t3_order", 64'(order_code()), 64'h12303);

    foreach (tbl[i]) begin
      dut_beats = 0; dut_err_seen = 1'b0; dut_mv_seen = 1'b0;
      grants.delete();
      req(tbl[i].req, tbl[i].ln, tbl[i].ad);
      run_until_idle(200, "tbl");
      cmp($sformatf("tbl%0d_gnt", i), 64'(order_code()), 64'(16 + tbl[i].req));
      cmp($sformatf("tbl%0d_beats", i), 64'(dut_beats), 64'(tbl[i].beats));
      cmp($sformatf("tbl%0d_zero_err", i), 64'(dut_err_seen), 64'(tbl[i].zero));
      cmp($sformatf("tbl%0d_fwd", i), 64'(dut_mv_seen), 64'(!tbl[i].zero));
    end

    // rr_ptr=2 after serving requester 1: 2 beats 0 when both ask.
    grants.delete();
    req(1, 8, 32'h100);
    run_until_idle(20, "t1a");
    req(0, 4, 32'h40); req(2, 4, 32'h80);
    run_until_idle(40, "t1b");
    cmp("t1_order", 64'(order_code()), 64'h1120);

    // Stalling bridge: ready 1,0,0,1,... over a 4-beat transfer.
    dut_beats = 0;
    req(1, 16, 32'h500);
    c = 0;
    while ((v != '0 || ms != 0) && c < 100) begin
      m_wready = (c % 3 == 0);
      cycle();
      c++;
    end
    if (c >= 100) timeout("t5");
    cmp("t5_beats", 64'(dut_beats), 64'd4);
    m_wready = 1'b1;

    // Randomized traffic against the reference.
    rnd_mode = 1'b1;
    for (int n = 0; n < 800; n++) begin
      for (int k = 0; k < N; k++) begin
        if (!v[k] && $urandom_range(0, 3) == 0)
          req(k, ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 24)), $urandom);
        else if (v[k] && !(ms != 0 && mg == k) && $urandom_range(0, 15) == 0)
          v[k] = 1'b0;
      end
      m_wready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    rnd_mode = 1'b0;
    m_wready = 1'b1;
    run_until_idle(400, "rnd_drain");

    // Reset during beat 2 of a 3-beat transfer; requester 1 pending.
    grants.delete();
    req(0, 12, 32'h600);
    cycle();
    req(1, 4, 32'h700);
    cycle();
    cycle();
    #3;
    rst_n = 1'b0;
    #1;
    reset_check("midreset");
    v[0] = 1'b0;
    ms = 0; mg = 0; mrr = 0; mbeat = 0;
    grants.delete();
    @(negedge clk);
    rst_n = 1'b1;
    cycle();
    run_until_idle(20, "t6");
    cmp("t6_order", 64'(order_code()), 64'h11);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
